// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor counter table: counter state
// names for the 2-bit case and width-generic saturating counter helpers.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr2_e;

    // Weakly-not-taken: the largest value whose MSB is still clear.
    function automatic logic [31:0] ctr_init(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_next(input logic [31:0] ctr,
                                             input logic        taken,
                                             input int unsigned ctr_w);
        logic [31:0] top;
        top = (ctr_w >= 32) ? '1 : ((32'd1 << ctr_w) - 32'd1);
        if (taken)
            return (ctr == top) ? ctr : ctr + 32'd1;
        else
            return (ctr == '0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational CTR_W-bit saturating up/down step; msb is the taken
// prediction of the stepped value.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] next,
    output logic             msb
);

    always_comb begin
        next = CTR_W'(ctr_next(32'(cur), taken, CTR_W));
        msb  = next[CTR_W-1];
    end

endmodule

// File: rtl/bp_counter_table.sv
// Table of 2^IDX_W saturating counters indexed by PC, 1-cycle prediction,
// read-modify-write update with same-cycle forwarding. Optional gshare
// indexing is enabled by defining GSHARE_EN.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned HIST_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             out_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [CTR_W-1:0] ctr_tbl [DEPTH];
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_next;
    logic             upd_msb;
    logic             fwd_hit;
    logic             unused_pc_bits;

    assign pc_idx         = pred_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

`ifdef GSHARE_EN
    logic [HIST_W-1:0] ghr;

    // Lookup uses the history as it stands before this cycle's update shifts it.
    assign lookup_idx = pc_idx ^ IDX_W'(ghr);

    always_ff @(posedge clk) begin
        if (reset)
            ghr <= '0;
        else if (upd_valid)
            ghr <= HIST_W'({ghr, upd_taken});
    end
`else
    localparam int unsigned UNUSED_HIST_W = HIST_W;
    assign lookup_idx = pc_idx;
`endif

    assign upd_cur = ctr_tbl[upd_idx];
    assign fwd_hit = upd_valid && (upd_idx == lookup_idx);

    bp_sat_counter #(
        .CTR_W (CTR_W)
    ) u_upd_ctr (
        .cur   (upd_cur),
        .taken (upd_taken),
        .next  (upd_next),
        .msb   (upd_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                ctr_tbl[i] <= CTR_W'(ctr_init(CTR_W));
            out_valid  <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
        end else begin
            if (upd_valid)
                ctr_tbl[upd_idx] <= upd_next;
            out_valid <= pred_valid;
            if (pred_valid) begin
                pred_idx   <= lookup_idx;
                pred_taken <= fwd_hit ? upd_msb : ctr_tbl[lookup_idx][CTR_W-1];
            end
        end
    end

endmodule

// File: tb/tb_bp_counter_table.sv
// Scoreboard bench for bp_counter_table: directed scenarios plus random
// traffic checked against an array-based reference predictor.
module tb_bp_counter_table;

    localparam int PC_W   = 32;
    localparam int IDX_W  = 4;
    localparam int CTR_W  = 2;
    localparam int HIST_W = 4;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int CMAX   = (1 << CTR_W) - 1;
    localparam int CINIT  = (1 << (CTR_W - 1)) - 1;
    localparam int THRESH = 1 << (CTR_W - 1);

    logic             clk;
    logic             reset;
    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             out_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    bp_counter_table #(
        .PC_W   (PC_W),
        .IDX_W  (IDX_W),
        .CTR_W  (CTR_W),
        .HIST_W (HIST_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_pc    (pred_pc),
        .out_valid  (out_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit t;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference predictor state
    int model_ctr [DEPTH];
    int model_ghr;
    bit held_t;
    int held_idx;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_ctr[i] = CINIT;
        model_ghr = 0;
        held_t    = 0;
        held_idx  = 0;
    endtask

    task automatic cycle(input bit rst, input bit pv, input logic [31:0] pc,
                         input bit uv, input int uidx, input bit ut);
        exp_t e;
        int   pidx;
        @(negedge clk);
        reset      = rst;
        pred_valid = pv;
        pred_pc    = pc;
        upd_valid  = uv;
        upd_idx    = IDX_W'(uidx);
        upd_taken  = ut;
        if (rst) begin
            model_reset();
            e.v = 0;
        end else begin
            pidx = (pc >> 2) % DEPTH;
`ifdef GSHARE_EN
            pidx = pidx ^ model_ghr;
`endif
            // The update lands first so a same-index prediction sees its result.
            if (uv) begin
                if (ut) model_ctr[uidx] = (model_ctr[uidx] == CMAX) ? CMAX : model_ctr[uidx] + 1;
                else    model_ctr[uidx] = (model_ctr[uidx] == 0) ? 0 : model_ctr[uidx] - 1;
`ifdef GSHARE_EN
                model_ghr = ((model_ghr << 1) | int'(ut)) % (1 << HIST_W);
`endif
            end
            if (pv) begin
                held_t   = (model_ctr[pidx] >= THRESH);
                held_idx = pidx;
            end
            e.v = pv;
        end
        e.t   = held_t;
        e.idx = held_idx;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 0, 0, 0);
    endtask

    // Monitor: one scoreboard entry per clocked cycle, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_valid !== e.v) begin
                    failures++;
                    $display("FAIL out_valid: got %b expected %b at %0t", out_valid, e.v, $time);
                end
                checks++;
                if (pred_taken !== e.t) begin
                    failures++;
                    $display("FAIL pred_taken: got %b expected %b at %0t", pred_taken, e.t, $time);
                end
                checks++;
                if (pred_idx !== IDX_W'(e.idx)) begin
                    failures++;
                    $display("FAIL pred_idx: got %h expected %h at %0t", pred_idx, e.idx, $time);
                end
            end
        end
    end

    initial begin
        bit pv, uv, ut, rst;
        int ui;
        logic [31:0] pc;

        reset = 1; pred_valid = 0; pred_pc = '0; upd_valid = 0; upd_idx = '0; upd_taken = 0;
        model_reset();

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Scenario 1: fresh table predicts not-taken at index 0
        cycle(0, 1, 32'h40, 0, 0, 0);
        idle();

        // Scenario 2: saturate index 3 upward
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h0C, 1, 3, 1);
        cycle(0, 1, 32'h0C, 0, 0, 0);

        // Scenario 3: index 5 down to floor, then back up
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 5, 0);
        cycle(0, 0, 0, 1, 5, 1);
        cycle(0, 1, 32'h14, 0, 0, 0);
        cycle(0, 0, 0, 1, 5, 1);
        cycle(0, 1, 32'h14, 0, 0, 0);

        // Scenario 4: same-cycle update and predict to index 7
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h1C, 1, 7, 1);
        cycle(0, 1, 32'h1C, 0, 0, 0);

        // Scenario 5: reset discards concurrent request and update
        cycle(0, 0, 0, 1, 2, 1);
        cycle(0, 0, 0, 1, 2, 1);
        cycle(1, 1, 32'h08, 1, 2, 1);
        cycle(0, 1, 32'h08, 0, 0, 0);
        idle();

        // Scenario 6: history pattern T,T,N,T then predict pc 0x08
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 9, 1);
        cycle(0, 0, 0, 1, 9, 1);
        cycle(0, 0, 0, 1, 9, 0);
        cycle(0, 0, 0, 1, 9, 1);
        cycle(0, 1, 32'h08, 0, 0, 0);
        idle();

        // Random traffic with prediction index biased towards the update index
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            pv  = ($urandom_range(0, 3) != 0);
            uv  = ($urandom_range(0, 2) != 0);
            ut  = $urandom_range(0, 1);
            ui  = $urandom_range(0, DEPTH - 1);
            pc  = $urandom;
            if ($urandom_range(0, 1) == 1)
                pc[IDX_W+1:2] = IDX_W'(ui);
            cycle(rst, pv, pc, uv, ui, ut);
        end

        idle();
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
